// File: rtl/clock_domain_export_pkg.sv
// Shared definitions for the source side of the valid/ack clock crossing.
// Holds the handshake FSM state encoding and the ack synchroniser depth.
package clock_domain_export_pkg;

    localparam int SYNC_STAGES = 2;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETUP   = 2'd1;
    localparam logic [1:0] VALID   = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

endpackage

// File: rtl/clock_domain_export_if.sv
// Two-wire valid/ack crossing bundle between source and destination domains.
// The master presents data/valid; the slave returns ack.
interface clock_domain_export_if #(
    parameter int SIZE = 8
);

    logic [SIZE-1:0] handshake_data;
    logic            handshake_valid;
    logic            handshake_ack;

    modport master (
        output handshake_data,
        output handshake_valid,
        input  handshake_ack
    );

    modport slave (
        input  handshake_data,
        input  handshake_valid,
        output handshake_ack
    );

endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO with push/pop/full/empty and async active-low reset.
// Reusable on both sides of the crossing.
module fifo_sync #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [SIZE-1:0] wdata,
    input  logic            pop,
    output logic [SIZE-1:0] rdata,
    output logic            full,
    output logic            empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/clock_domain_export.sv
// Source side of the valid/ack crossing: FIFO, ack synchroniser, handshake FSM.
// CLOCK_DOMAIN_EXPORT_STATS_EN adds a saturating 16-bit dropped-word counter.
module clock_domain_export
    import clock_domain_export_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SIZE-1:0]       data,
    input  logic                  stb,
    output logic                  ready,
    clock_domain_export_if.master hs
`ifdef CLOCK_DOMAIN_EXPORT_STATS_EN
    ,
    output logic [15:0]           dropped
`endif
);

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [SIZE-1:0]        hd_q;
    logic                   hv_q;
    logic [SIZE-1:0]        head;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;

    assign ready = !full;
    assign push  = stb && !full;
    assign pop   = (state == IDLE) && !empty;
    assign ack_s = ack_sync[SYNC_STAGES-1];

    assign hs.handshake_data  = hd_q;
    assign hs.handshake_valid = hv_q;

    fifo_sync #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Preset high so a restart waits for the destination to show ack low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '1;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], hs.handshake_ack};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RELEASE;
            hd_q  <= '0;
            hv_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        hd_q  <= head;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    hv_q  <= 1'b1;
                    state <= VALID;
                end
                VALID: begin
                    if (ack_s) begin
                        hv_q  <= 1'b0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef CLOCK_DOMAIN_EXPORT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped <= '0;
        end else if (stb && full && (dropped != 16'hFFFF)) begin
            dropped <= dropped + 16'd1;
        end
    end
`endif

endmodule
